// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its multiplier.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    // Opcode encoding as presented on the op port.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    // Control FSM: waiting for an op, iterating a multiply, holding a result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// The first partial product is formed on the start edge, so the final
// product sits in prod_q and done pulses WIDTH-1 edges after start.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // One iteration: conditionally add the multiplicand to the upper half,
    // then shift the whole register right (multiplier bits drain from the bottom).
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
        return {sum, p[WIDTH-1:1]};
    endfunction

    // Next-state for the iteration datapath and its counter.
    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start) begin
            prod_d  = mul_step({{WIDTH{1'b0}}, b}, a);
            mcand_d = a;
            cnt_d   = CW'(1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            prod_d = mul_step(prod_q, mcand_q);
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Iteration state registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and N/Z/C/V flags.
// Single-cycle ops complete on the accept edge; MUL runs the iterative
// multiplier for WIDTH cycles. Result and flags hold until the next write.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                flag_n,
    output logic                flag_z,
    output logic                flag_c,
    output logic                flag_v
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    alu_op_e          op_e;
    logic             accept;
    logic             load_alu;
    logic             load_mul;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [SW-1:0]    shamt;

    assign op_e      = alu_op_e'(op);
    assign accept    = in_valid && in_ready;
    assign load_alu  = accept && (op_e != ALU_MUL);
    assign load_mul  = (state_q == ST_MUL) && mul_done;
    assign mul_start = accept && (op_e == ALU_MUL) && !mul_busy;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath: adder/subtractor, logic ops and barrel shifts.
    // Shifts carry an extra bit so the last bit shifted out lands there
    // (and is naturally 0 for a zero shift amount).
    always_comb begin
        shamt   = op_b[SW-1:0];
        add_sum = {1'b0, op_a} + {1'b0, op_b};
        sub_sum = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
        shl_ext = {1'b0, op_a} << shamt;
        shr_ext = {op_a, 1'b0} >> shamt;
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_e)
            ALU_ADD: begin
                alu_r = add_sum[WIDTH-1:0];
                alu_c = add_sum[WIDTH];
                alu_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_r[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_r = sub_sum[WIDTH-1:0];
                alu_c = sub_sum[WIDTH];
                alu_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_r[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND: alu_r = op_a & op_b;
            ALU_OR:  alu_r = op_a | op_b;
            ALU_XOR: alu_r = op_a ^ op_b;
            ALU_SHL: begin
                alu_r = shl_ext[WIDTH-1:0];
                alu_c = shl_ext[WIDTH];
            end
            ALU_SHR: begin
                alu_r = shr_ext[WIDTH:1];
                alu_c = shr_ext[0];
            end
            default: ;
        endcase
    end

    // Result/flag writeback: only on entry to DONE, otherwise hold.
    always_comb begin
        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        if (load_alu) begin
            result_d = alu_r;
            n_d      = alu_r[WIDTH-1];
            z_d      = (alu_r == '0);
            c_d      = alu_c;
            v_d      = alu_v;
        end else if (load_mul) begin
            result_d = mul_product[WIDTH-1:0];
            n_d      = mul_product[WIDTH-1];
            z_d      = (mul_product[WIDTH-1:0] == '0);
            c_d      = (mul_product[2*WIDTH-1:WIDTH] != '0);
            v_d      = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (op_e == ALU_MUL) ? ST_MUL : ST_DONE;
            end
            ST_MUL: begin
                if (mul_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs depend only on state (and reset for in_ready).
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
    end

    assign result = result_q;
    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH = 32) with an expected-result scoreboard.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_n, flag_z, flag_c, flag_v;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] r;
        logic [3:0]  f;   // {N,Z,C,V}
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the presented result.
    task automatic pop_check();
        exp_t e;
        chk_int("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk32({e.tag, "_result"}, result, e.r);
            chk32({e.tag, "_flags_nzcv"}, {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, e.f});
            $display("txn %-10s result=0x%08h nzcv=%b%b%b%b", e.tag, result, flag_n, flag_z, flag_c, flag_v);
        end
    endtask

    // Complete the output handshake and confirm the block returns to IDLE.
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk32({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
        chk32({tag, "_iready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Drive one op, measure latency from the accept cycle, then check and retire it.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f, input int exp_lat,
                         input string tag);
        int lat;
        int w;
        sb.push_back('{tag, r, f});
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        op = o; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op   = 3'($urandom);
        op_a = $urandom;
        op_b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_int({tag, "_latency"}, lat, exp_lat);
        pop_check();
        handshake(tag);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; op = '0; op_a = '0; op_b = '0; out_ready = 1'b0;
        #12;
        chk32("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        chk32("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk32("rst_result",    result, 32'd0);
        chk32("rst_flags",     {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk32("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Arithmetic, logic, shift and multiply cases.
        issue(3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1, "add_ovf");
        issue(3'b001, 32'd5,        32'd5,        32'h00000000, 4'b0110, 1, "sub_eq");
        issue(3'b001, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b1000, 1, "sub_brw");
        issue(3'b111, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0110, 33, "mul_hi");
        issue(3'b111, 32'd7,        32'd6,        32'd42,       4'b0000, 33, "mul_42");
        issue(3'b101, 32'h80000001, 32'd1,        32'h00000002, 4'b0010, 1, "shl_1");
        issue(3'b110, 32'h12345678, 32'd0,        32'h12345678, 4'b0000, 1, "shr_0");
        issue(3'b110, 32'h00000003, 32'd1,        32'h00000001, 4'b0010, 1, "shr_1");
        issue(3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1, "and");
        issue(3'b011, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100, 1, "or_zero");
        issue(3'b100, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'b1000, 1, "xor");

        // Backpressure: hold the result while a new op waits on in_valid.
        sb.push_back('{"bp_xor", 32'h5A5A5A5A, 4'b0000});
        @(negedge clk);
        op = 3'b100; op_a = 32'hA5A5A5A5; op_b = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        chk32("bp_first_valid", {31'd0, out_valid}, 32'd1);
        pop_check();
        sb.push_back('{"bp_add", 32'd2, 4'b0000});
        op = 3'b000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk32("bp_hold_result", result, 32'h5A5A5A5A);
            chk32("bp_hold_ctrl", {29'd0, out_valid, in_ready, flag_n | flag_z | flag_c | flag_v}, 32'b100);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk32("bp_hs_ovalid", {31'd0, out_valid}, 32'd0);
        chk32("bp_hs_iready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk32("bp_second_valid", {31'd0, out_valid}, 32'd1);
        pop_check();
        handshake("bp_add");

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        op = 3'b111; op_a = 32'h0000FFFF; op_b = 32'h0000FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk32("abort_ovalid", {31'd0, out_valid}, 32'd0);
        chk32("abort_iready", {31'd0, in_ready}, 32'd0);
        chk32("abort_state",  {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        chk32("abort_result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk32("abort_rel_iready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk_int("abort_no_result", seen, 0);
        issue(3'b000, 32'd2, 32'd3, 32'd5, 4'b0000, 1, "add_after");

        chk_int("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
